y86_wb_regfile: RTL and testbench

Parametrised write-back stage and register file for the pipelined Y86-64 core. It holds a W pipeline register, decodes destinations from the registered icode and commits up to two results per cycle: valE to dstE and valM to dstM. It provides two bypassed read ports for decode, a debug read port, sticky halt/error flags and a retired-instruction counter. It sits between the memory stage and decode, and replaces the single-cycle write-back block of the sequential core.

---
 rtl/y86_wb_regfile.sv | 173 +++++++++++++++++
 tb/tb_y86_wb_regfile.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/y86_wb_regfile.sv
// Write-back stage and register file for the pipelined Y86-64 core: W pipeline register,
// dual-destination commit, bypassed decode read ports, sticky halt/error and retired counter.
module y86_wb_regfile #(
  parameter int         DATA_W = 64,
  parameter int         NREGS  = 15,
  parameter logic [3:0] RNONE  = 4'hF,
  parameter int         CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_stall,
  input  logic              in_bubble,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic              in_cond,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [DATA_W-1:0] in_valM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_RSP  = 4'h4;

  logic              w_valid;
  logic [3:0]        w_icode;
  logic [3:0]        w_rA;
  logic [3:0]        w_rB;
  logic              w_cond;
  logic [DATA_W-1:0] w_valE;
  logic [DATA_W-1:0] w_valM;

  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic              dst_e_ok;
  logic              dst_m_ok;
  logic              fire;
  logic              w_halt;
  logic              w_bad;
  logic              byp_ok;
  logic [DATA_W-1:0] arr_a;
  logic [DATA_W-1:0] arr_b;
  logic [DATA_W-1:0] arr_dbg;

  function automatic logic reg_ok(input logic [3:0] a);
    return (a != RNONE) && (int'(a) < NREGS);
  endfunction

  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (w_icode)
      I_CMOVXX:         dst_e = w_cond ? w_rB : RNONE;
      I_IRMOVQ, I_OPQ:  dst_e = w_rB;
      I_MRMOVQ:         dst_m = w_rA;
      I_CALL, I_RET,
      I_PUSHQ:          dst_e = REG_RSP;
      I_POPQ: begin
        dst_e = REG_RSP;
        dst_m = w_rA;
      end
      default: begin
        dst_e = RNONE;
        dst_m = RNONE;
      end
    endcase
  end

  assign dst_e_ok = reg_ok(dst_e);
  assign dst_m_ok = reg_ok(dst_m);
  assign fire     = w_valid & ~in_stall & ~halted;
  assign w_halt   = (w_icode == I_HALT);
  assign w_bad    = (w_icode > I_POPQ);
  assign byp_ok   = w_valid & ~halted;

  // Once halted the W register is frozen, so the halt's successor can never commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_icode <= '0;
      w_rA    <= '0;
      w_rB    <= '0;
      w_cond  <= 1'b0;
      w_valE  <= '0;
      w_valM  <= '0;
    end else if (!halted && !in_stall) begin
      if (in_bubble) begin
        w_valid <= 1'b0;
      end else begin
        w_valid <= in_valid;
        w_icode <= in_icode;
        w_rA    <= in_rA;
        w_rB    <= in_rB;
        w_cond  <= in_cond;
        w_valE  <= in_valE;
        w_valM  <= in_valM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted  <= 1'b0;
      err     <= 1'b0;
      retired <= '0;
    end else if (fire) begin
      retired <= retired + CNT_W'(1);
      if (w_halt || w_bad) halted <= 1'b1;
      if (w_bad) err <= 1'b1;
    end
  end

  // valM is checked first so that popq %rsp leaves the popped value in %rsp.
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    localparam logic [3:0] IDX = 4'(g);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[g] <= '0;
      end else if (fire && dst_m_ok && (dst_m == IDX)) begin
        regs[g] <= w_valM;
      end else if (fire && dst_e_ok && (dst_e == IDX)) begin
        regs[g] <= w_valE;
      end
    end
  end

  always_comb begin
    arr_a   = '0;
    arr_b   = '0;
    arr_dbg = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (srcA == 4'(i)) arr_a = regs[i];
      if (srcB == 4'(i)) arr_b = regs[i];
      if (dbg_addr == 4'(i)) arr_dbg = regs[i];
    end
  end

  always_comb begin
    valA = arr_a;
    if (!reg_ok(srcA)) valA = '0;
    else if (byp_ok && (dst_m == srcA)) valA = w_valM;
    else if (byp_ok && (dst_e == srcA)) valA = w_valE;
  end

  always_comb begin
    valB = arr_b;
    if (!reg_ok(srcB)) valB = '0;
    else if (byp_ok && (dst_m == srcB)) valB = w_valM;
    else if (byp_ok && (dst_e == srcB)) valB = w_valE;
  end

  assign dbg_data = reg_ok(dbg_addr) ? arr_dbg : '0;

endmodule

// File: tb/tb_y86_wb_regfile.sv
// Directed bench for y86_wb_regfile; register writes are scored through a queue drained via dbg_data.
module tb_y86_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_stall;
  logic        in_bubble;
  logic [3:0]  in_icode;
  logic [3:0]  in_rA;
  logic [3:0]  in_rB;
  logic        in_cond;
  logic [63:0] in_valE;
  logic [63:0] in_valM;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dbg_addr;
  logic [63:0] valA, valB, dbg_data;
  logic        halted, err;
  logic [31:0] retired;
  logic [63:0] valA4, valB4, dbg_data4;
  logic        halted4, err4;
  logic [3:0]  retired4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  y86_wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_stall(in_stall), .in_bubble(in_bubble),
    .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB), .in_cond(in_cond),
    .in_valE(in_valE), .in_valM(in_valM), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .halted(halted), .err(err), .retired(retired)
  );

  y86_wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_stall(in_stall), .in_bubble(in_bubble),
    .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB), .in_cond(in_cond),
    .in_valE(in_valE), .in_valM(in_valM), .srcA(srcA), .srcB(srcB),
    .valA(valA4), .valB(valB4), .dbg_addr(dbg_addr), .dbg_data(dbg_data4),
    .halted(halted4), .err(err4), .retired(retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectReg(input logic [3:0] addr, input logic [63:0] val);
    sb.push_back('{addr, val});
  endtask

  task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                               input logic cond, input logic [63:0] ve, input logic [63:0] vm);
    in_valid = 1'b1;
    in_icode = icode;
    in_rA    = ra;
    in_rB    = rb;
    in_cond  = cond;
    in_valE  = ve;
    in_valM  = vm;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      dbg_addr = e.addr;
      #1;
      chk($sformatf("%s_reg%0d", tag, e.addr), dbg_data, e.val);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    srcA = 4'd2;
    srcB = 4'd4;
    dbg_addr = 4'd2;
    #1;
    chk({tag, "_valA"}, valA, 64'd0);
    chk({tag, "_valB"}, valB, 64'd0);
    chk({tag, "_dbg"}, dbg_data, 64'd0);
    chk({tag, "_retired"}, {32'd0, retired}, 64'd0);
    chk({tag, "_halted"}, {63'd0, halted}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_stall = 1'b0; in_bubble = 1'b0;
    in_icode = 4'h1; in_rA = 4'hF; in_rB = 4'hF; in_cond = 1'b0;
    in_valE = '0; in_valM = '0;
    srcA = 4'hF; srcB = 4'hF; dbg_addr = 4'hF;
    #2;
    $display("[TB] reset state");
    checkResetOutputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] irmovq with bypass");
    srcB = 4'd2;
    applyStimulus(4'h3, 4'hF, 4'd2, 1'b0, 64'h1234, 64'h0);
    dbg_addr = 4'd2;
    #1;
    chk("irmov_bypass_valB", valB, 64'h1234);
    chk("irmov_array_before_commit", dbg_data, 64'd0);
    expectReg(4'd2, 64'h1234);
    tick();
    checkOutput("irmov");
    chk("irmov_retired", {32'd0, retired}, 64'd1);
    chk("irmov_valB_from_array", valB, 64'h1234);

    $display("[TB] popq");
    applyStimulus(4'hB, 4'd4, 4'hF, 1'b0, 64'h100, 64'hBEEF);
    expectReg(4'd4, 64'hBEEF);
    tick();
    checkOutput("popq_rsp");
    applyStimulus(4'hB, 4'd3, 4'hF, 1'b0, 64'h200, 64'hCAFE);
    expectReg(4'd4, 64'h200);
    expectReg(4'd3, 64'hCAFE);
    tick();
    checkOutput("popq_r3");
    chk("popq_retired", {32'd0, retired}, 64'd3);

    $display("[TB] cmovxx");
    applyStimulus(4'h2, 4'hF, 4'd5, 1'b0, 64'd7, 64'd0);
    expectReg(4'd5, 64'd0);
    tick();
    checkOutput("cmov_nc");
    chk("cmov_nc_retired", {32'd0, retired}, 64'd4);
    applyStimulus(4'h2, 4'hF, 4'd5, 1'b1, 64'd7, 64'd0);
    expectReg(4'd5, 64'd7);
    tick();
    checkOutput("cmov_c");
    chk("cmov_c_retired", {32'd0, retired}, 64'd5);

    $display("[TB] stall and stall+bubble");
    srcA = 4'd1;
    applyStimulus(4'h6, 4'hF, 4'd1, 1'b0, 64'h55, 64'h0);
    in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_bubble = (i == 2);
      tick();
      dbg_addr = 4'd1;
      #1;
      chk($sformatf("stall%0d_retired", i), {32'd0, retired}, 64'd5);
      chk($sformatf("stall%0d_bypass", i), valA, 64'h55);
      chk($sformatf("stall%0d_array", i), dbg_data, 64'd0);
    end
    in_stall = 1'b0;
    in_bubble = 1'b0;
    expectReg(4'd1, 64'h55);
    tick();
    checkOutput("opq_after_stall");
    chk("opq_retired", {32'd0, retired}, 64'd6);

    $display("[TB] invalid icode");
    applyStimulus(4'hC, 4'd2, 4'd2, 1'b1, 64'hDEAD, 64'hDEAD);
    expectReg(4'd2, 64'h1234);
    tick();
    checkOutput("bad");
    chk("bad_err", {63'd0, err}, 64'd1);
    chk("bad_halted", {63'd0, halted}, 64'd1);
    chk("bad_retired", {32'd0, retired}, 64'd7);
    chk("bad_retired4", {60'd0, retired4}, 64'd7);

    $display("[TB] mid-run reset");
    rst_n = 1'b0;
    checkResetOutputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] halt blocks successor");
    srcA = 4'd6;
    applyStimulus(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    applyStimulus(4'h3, 4'hF, 4'd6, 1'b0, 64'h66, 64'h0);
    tick();
    tick();
    expectReg(4'd6, 64'd0);
    checkOutput("halt");
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_err", {63'd0, err}, 64'd0);
    chk("halt_retired", {32'd0, retired}, 64'd1);
    chk("halt_no_bypass", valA, 64'd0);

    $display("[TB] counter wrap");
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    tick();
    chk("wrap_retired32", {32'd0, retired}, 64'd16);
    chk("wrap_retired4", {60'd0, retired4}, 64'd0);
    chk("wrap_halted", {63'd0, halted}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
